// File: rtl/bloonstd1_soc_strobe_tx.sv
// Avalon-MM strobe transmitter: DATA/LEN/CONTROL/STATUS registers
// driving out_port with a LEN+1 cycle out_strobe pulse.
module bloonstd1_soc_strobe_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  out_strobe
);

  typedef enum logic {
    IDLE,
    STROBE
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0] data;
  logic [7:0]            len;
  logic [7:0]            count;
  logic                  done;
  logic                  overrun;
  logic [31:0]           rd_next;

  logic wr;
  logic wr_data;
  logic wr_len;
  logic wr_ctrl;
  logic wr_status;
  logic start;
  logic busy;
  logic launch;
  logic last;
  logic unused_bits;

  assign wr        = chipselect & ~write_n;
  assign wr_data   = wr & (address == 2'd0);
  assign wr_len    = wr & (address == 2'd1);
  assign wr_ctrl   = wr & (address == 2'd2);
  assign wr_status = wr & (address == 2'd3);

  assign start  = wr_ctrl & writedata[0];
  assign busy   = (state == STROBE);
  assign launch = start & ~busy;
  assign last   = busy & (count == 8'd0);

  // Not every writedata bit reaches a register.
  assign unused_bits = ^writedata;

  // Next-state logic: START launches from IDLE, counter expiry ends STROBE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:   if (launch) state_next = STROBE;
      STROBE: if (count == 8'd0) state_next = IDLE;
    endcase
  end

  // State register; out_strobe mirrors the registered state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      out_strobe <= 1'b0;
    end else begin
      state      <= state_next;
      out_strobe <= (state_next == STROBE);
    end
  end

  // Down-counter: loaded at launch, decremented while strobing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (launch) begin
      count <= len;
    end else if (busy && count != 8'd0) begin
      count <= count - 8'd1;
    end
  end

  // Output word is captured only when a transfer is launched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= RESET_VALUE;
    end else if (launch) begin
      out_port <= data;
    end
  end

  // Software-visible DATA and LEN registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
      len  <= 8'd0;
    end else begin
      if (wr_data) data <= writedata[DATA_WIDTH-1:0];
      if (wr_len)  len  <= writedata[7:0];
    end
  end

  // Sticky flags: write-one-to-clear, a same-edge set takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      done    <= (done & ~(wr_status & writedata[1])) | last;
      overrun <= (overrun & ~(wr_status & writedata[2])) |
                 (start & busy);
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_next = '0;
    unique case (address)
      2'd0: rd_next[DATA_WIDTH-1:0] = data;
      2'd1: rd_next[7:0] = len;
      2'd2: rd_next = '0;
      2'd3: rd_next[2:0] = {overrun, done, busy};
    endcase
  end

  // Read data is registered every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_bloonstd1_soc_strobe_tx.sv
// Scoreboard bench for bloonstd1_soc_strobe_tx: transaction model
// predicts read data and strobe bursts, monitors compare them.
module tb_bloonstd1_soc_strobe_tx;

  localparam int unsigned DW = 8;
  localparam logic [DW-1:0] RV = 8'h3C;

  logic          clk;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;
  logic          out_strobe;

  bloonstd1_soc_strobe_tx #(
    .DATA_WIDTH (DW),
    .RESET_VALUE(RV)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port),
    .out_strobe(out_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            len;
  } burst_t;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rq[$];
  burst_t      bq[$];
  logic        rd_req = 1'b0;
  logic        rd_pend = 1'b0;

  // Reference model: registers plus remaining strobe cycles.
  logic [DW-1:0] m_data;
  logic [7:0]    m_len;
  logic          m_done;
  logic          m_ovr;
  int            m_rem;

  // Monitor-side state.
  logic          in_burst = 1'b0;
  int            cnt = 0;
  burst_t        cur;
  logic [DW-1:0] last_out = RV;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_data = RV;
    m_len  = 8'd0;
    m_done = 1'b0;
    m_ovr  = 1'b0;
    m_rem  = 0;
  endtask

  // One bus cycle: drive inputs, predict read data, advance the model.
  task automatic cyc(input logic [1:0] a, input logic cs,
                     input logic wn, input logic [31:0] wd);
    logic busy;
    logic start;
    logic cd;
    logic co;
    logic [31:0] e;
    @(negedge clk);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    busy = (m_rem > 0);
    case (a)
      2'd0:    e = {24'd0, m_data};
      2'd1:    e = {24'd0, m_len};
      2'd2:    e = 32'd0;
      default: e = {29'd0, m_ovr, m_done, busy};
    endcase
    rq.push_back(e);
    rd_req = 1'b1;
    start = 1'b0;
    cd = 1'b0;
    co = 1'b0;
    if (cs && !wn) begin
      case (a)
        2'd0:    m_data = wd[DW-1:0];
        2'd1:    m_len = wd[7:0];
        2'd2:    start = wd[0];
        default: begin
          cd = wd[1];
          co = wd[2];
        end
      endcase
    end
    m_done = (m_done & ~cd) | (m_rem == 1);
    m_ovr  = (m_ovr & ~co) | (start & busy);
    if (start && !busy) begin
      bq.push_back('{data: m_data, len: int'(m_len) + 1});
      m_rem = int'(m_len) + 1;
    end else if (busy) begin
      m_rem--;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(a, 1'b1, 1'b1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(2'd3, 1'b0, 1'b1, 32'd0);
  endtask

  // Reset asserted mid-cycle, checked before any further clock edge.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_strobe", {31'd0, out_strobe}, 32'd0);
    chk("rst_port", {24'd0, out_port}, {24'd0, RV});
    chk("rst_readdata", readdata, 32'd0);
    model_reset();
    chipselect = 1'b0;
    write_n    = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  // Read-data pipeline tracker.
  always @(posedge clk) begin
    rd_pend = rd_req;
    rd_req  = 1'b0;
  end

  // Monitor: read data and strobe bursts against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rd_pend) begin
      e = rq.pop_front();
      if (reset_n) chk("readdata", readdata, e);
      rd_pend = 1'b0;
    end
    if (!reset_n) begin
      if (in_burst) begin
        chk("abort_short", {31'd0, cnt < cur.len}, 32'd1);
        in_burst = 1'b0;
      end
      last_out = RV;
    end else if (out_strobe) begin
      if (!in_burst) begin
        chk("burst_expected", {31'd0, bq.size() != 0}, 32'd1);
        if (bq.size() != 0) cur = bq.pop_front();
        else cur = '{data: '0, len: 0};
        in_burst = 1'b1;
        cnt = 0;
      end
      cnt++;
      chk("port_strobe", {24'd0, out_port}, {24'd0, cur.data});
    end else begin
      if (in_burst) begin
        chk("strobe_len", cnt, cur.len);
        last_out = cur.data;
        in_burst = 1'b0;
      end
      chk("port_idle", {24'd0, out_port}, {24'd0, last_out});
    end
  end

  initial begin
    logic [1:0]  a;
    logic [31:0] d;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    reset_n    = 1'b1;
    model_reset();
    #3;
    reset_n = 1'b0;
    #1;
    chk("init_strobe", {31'd0, out_strobe}, 32'd0);
    chk("init_port", {24'd0, out_port}, {24'd0, RV});
    chk("init_readdata", readdata, 32'd0);
    repeat (2) @(negedge clk);
    #2;
    reset_n = 1'b1;

    rd(2'd0);
    rd(2'd1);
    rd(2'd3);

    // Basic transfer.
    wr(2'd0, 32'h0000_00A5);
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd1);
    idle(5);
    rd(2'd3);
    rd(2'd2);

    // Minimum length.
    wr(2'd3, 32'h6);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd1);
    idle(2);
    rd(2'd3);

    // Overrun.
    wr(2'd3, 32'h6);
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd1);
    idle(1);
    wr(2'd2, 32'd1);
    rd(2'd3);
    idle(10);
    wr(2'd3, 32'h6);
    rd(2'd3);

    // CONTROL write without START.
    wr(2'd2, 32'hFFFF_FFFE);
    idle(2);

    // Mid-transfer writes.
    wr(2'd0, 32'h11);
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'h22);
    wr(2'd1, 32'd1);
    rd(2'd0);
    idle(3);
    wr(2'd2, 32'd1);
    idle(3);

    // Set wins over a same-edge clear.
    wr(2'd3, 32'h6);
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd1);
    idle(2);
    wr(2'd3, 32'h2);
    rd(2'd3);
    wr(2'd3, 32'h2);
    rd(2'd3);

    // START on the final strobe edge.
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd1);
    idle(1);
    wr(2'd2, 32'd1);
    idle(2);
    rd(2'd3);

    // Longest strobe.
    wr(2'd1, 32'd255);
    wr(2'd0, 32'h5A);
    wr(2'd2, 32'd1);
    idle(258);

    // Reset mid-operation.
    wr(2'd0, 32'h77);
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd1);
    idle(1);
    mid_reset();
    rd(2'd0);
    rd(2'd1);
    rd(2'd2);
    rd(2'd3);
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd1);
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd1) d[7:0] = 8'($urandom_range(0, 12));
      cyc(a, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), d);
    end
    idle(20);

    @(negedge clk);
    @(negedge clk);
    #2;
    chk("rq_drained", rq.size(), 32'd0);
    chk("bq_drained", bq.size(), 32'd0);
    chk("burst_closed", {31'd0, in_burst}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
